// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, {re, im} sample packing and the
// index bit-reversal used to undo the FFT's bit-reversed output order.
package fft_pkg;

  localparam int NB_FFT  = 12;
  localparam int N_POINT = 8;
  localparam int LOG2_N  = 3;

  // re occupies the MSBs of the packed word, im the LSBs.
  typedef struct packed {
    logic signed [NB_FFT-1:0] re;
    logic signed [NB_FFT-1:0] im;
  } cplx_t;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
    logic [LOG2_N-1:0] rev;
    rev = '0;
    for (int b = 0; b < LOG2_N; b++) begin
      rev[b] = idx[LOG2_N-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer held in flops: one synchronous write port addressed by
// bank/address and one combinational read port addressed by bank/address.
module fft_pingpong_ram #(
  parameter int NB_WORD = 24,
  parameter int N_POINT = 8,
  parameter int LOG2_N  = 3
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic               i_wr_bank,
  input  logic [LOG2_N-1:0]  i_wr_addr,
  input  logic [NB_WORD-1:0] i_wr_data,
  input  logic               i_rd_bank,
  input  logic [LOG2_N-1:0]  i_rd_addr,
  output logic [NB_WORD-1:0] o_rd_data
);

  logic [NB_WORD-1:0] mem_q [2][N_POINT];

  // NOTE: storage is deliberately not reset; the bank-full flags in the
  // controller decide which words are valid, so stale contents are never read.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order through a
// ping-pong buffer, AXI-Stream in and out with full backpressure.
module fft_bitrev_reorder #(
  parameter int NB_DATA = fft_pkg::NB_FFT,
  parameter int N_POINT = fft_pkg::N_POINT,
  parameter int LOG2_N  = fft_pkg::LOG2_N
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 s_axis_data_tvalid,
  input  logic [2*NB_DATA-1:0] s_axis_data_tdata,
  input  logic                 s_axis_data_tlast,
  output logic                 s_axis_data_tready,
  output logic                 m_axis_data_tvalid,
  output logic [2*NB_DATA-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tlast,
  input  logic                 m_axis_data_tready,
  output logic                 o_frame_err
);

  import fft_pkg::*;

  localparam int                NB_WORD  = 2 * NB_DATA;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINT - 1);

  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [LOG2_N-1:0]  wr_idx_q, wr_idx_d;
  logic [LOG2_N-1:0]  rd_idx_q, rd_idx_d;
  logic               m_valid_q, m_valid_d;
  logic [NB_WORD-1:0] m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               frame_err_q, frame_err_d;

  logic               wr_hs;
  logic               rd_load;
  logic [LOG2_N-1:0]  wr_addr;
  logic [NB_WORD-1:0] rd_data;

  fft_pingpong_ram #(
    .NB_WORD (NB_WORD),
    .N_POINT (N_POINT),
    .LOG2_N  (LOG2_N)
  ) u_ram (
    .i_clk     (i_clk),
    .i_we      (wr_hs),
    .i_wr_bank (wr_bank_q),
    .i_wr_addr (wr_addr),
    .i_wr_data (s_axis_data_tdata),
    .i_rd_bank (rd_bank_q),
    .i_rd_addr (rd_idx_q),
    .o_rd_data (rd_data)
  );

  // NOTE: every signal driven here gets its default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_err_d = frame_err_q;

    wr_hs   = s_axis_data_tvalid && !full_q[wr_bank_q];
    wr_addr = bitrev(wr_idx_q);
    rd_load = (!m_valid_q || m_axis_data_tready) && full_q[rd_bank_q];

    // A short frame is dropped by rewinding the index; its bank stays open.
    if (wr_hs) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
        if (!s_axis_data_tlast) frame_err_d = 1'b1;
      end else if (s_axis_data_tlast) begin
        wr_idx_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    // Commit and release always target different banks, so both updates hold.
    if (rd_load) begin
      m_valid_d = 1'b1;
      m_data_d  = rd_data;
      m_last_d  = (rd_idx_q == LAST_IDX);
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end else if (m_axis_data_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_axis_data_tready = !full_q[wr_bank_q];
  assign m_axis_data_tvalid = m_valid_q;
  assign m_axis_data_tdata  = m_data_q;
  assign m_axis_data_tlast  = m_last_q;
  assign o_frame_err        = frame_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: table-driven single frame, then
// streaming, backpressure, framing-error and mid-frame reset sequences.
module tb_fft_bitrev_reorder;

  import fft_pkg::*;

  localparam int NW = 2 * NB_FFT;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic [NW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [NW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic          frame_err;

  fft_bitrev_reorder dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tlast  (s_tlast),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tlast  (m_tlast),
    .m_axis_data_tready (m_tready),
    .o_frame_err        (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arrival order of bins within a frame (3-bit bit-reversal, hand-computed).
  int rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    int   in_re;
    logic in_last;
    int   exp_re;
    int   exp_im;
    logic exp_last;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [NW-1:0] mk(input int re, input int im);
    cplx_t c;
    c.re = NB_FFT'(re);
    c.im = NB_FFT'(im);
    return c;
  endfunction

  // Output monitor: captures accepted beats and checks AXIS hold on stalls.
  logic [NW:0]   cap_q [$];
  int            cap_cyc [$];
  int            cyc       = 0;
  int            ready_low = 0;
  logic          mon_ready = 1'b0;
  logic          prev_stall = 1'b0;
  logic [NW-1:0] prev_data;
  logic          prev_last;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {31'd0, m_tvalid}, 32'd1);
          check("hold_data", {8'd0, m_tdata}, {8'd0, prev_data});
          check("hold_last", {31'd0, m_tlast}, {31'd0, prev_last});
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (m_tvalid && m_tready) begin
          cap_q.push_back({m_tdata, m_tlast});
          cap_cyc.push_back(cyc);
        end
        if (mon_ready && !s_tready) ready_low++;
      end
    end
  end

  // Backpressure pattern driver: tready follows 1,0,0,1 when enabled.
  logic bp_mode = 1'b0;
  logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_tready = bp_pat[k % 4];
        k++;
      end
    end
  end

  task automatic send_beat(input logic [NW-1:0] d, input logic l);
    logic hs;
    int   n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    hs = 1'b0;
    n  = 0;
    do begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 500);
    if (!hs) check("send_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int nbeats, input int last_at);
    for (int j = 0; j < nbeats; j++) begin
      send_beat(mk(base + rev_tab[j], -(base + rev_tab[j])), j == last_at);
    end
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 2000 && cap_q.size() < n; c++) @(posedge clk);
    #1;
    check("wait_beats", {31'd0, cap_q.size() >= n}, 32'd1);
  endtask

  task automatic check_frame(input string name, input int base);
    logic [NW:0] got;
    for (int k = 0; k < 8; k++) begin
      if (cap_q.size() == 0) begin
        check({name, "_missing"}, 32'd0, 32'd1);
      end else begin
        got = cap_q.pop_front();
        void'(cap_cyc.pop_front());
        check(name, {7'd0, got}, {7'd0, mk(base + k, -(base + k)), k == 7});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b0, 0,  0, 1'b0};
    tbl[1] = '{4, 1'b0, 1, -1, 1'b0};
    tbl[2] = '{2, 1'b0, 2, -2, 1'b0};
    tbl[3] = '{6, 1'b0, 3, -3, 1'b0};
    tbl[4] = '{1, 1'b0, 4, -4, 1'b0};
    tbl[5] = '{5, 1'b0, 5, -5, 1'b0};
    tbl[6] = '{3, 1'b0, 6, -6, 1'b0};
    tbl[7] = '{7, 1'b1, 7, -7, 1'b1};

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    #1;
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata", {8'd0, m_tdata}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("rst_tready", {31'd0, s_tready}, 32'd1);

    // Single frame from the vector table, with first-beat latency
    for (int i = 0; i < 8; i++) begin
      send_beat(mk(tbl[i].in_re, -tbl[i].in_re), tbl[i].in_last);
    end
    check("lat_edge1_tvalid", {31'd0, m_tvalid}, 32'd0);
    idle(1);
    check("lat_edge2_tvalid", {31'd0, m_tvalid}, 32'd1);
    check("lat_edge2_tdata", {8'd0, m_tdata}, {8'd0, mk(0, 0)});
    wait_beats(8);
    for (int i = 0; i < 8; i++) begin
      if (cap_q.size() == 0) begin
        check("single_missing", 32'd0, 32'd1);
      end else begin
        void'(cap_cyc.pop_front());
        check("single_beat", {7'd0, cap_q.pop_front()},
              {7'd0, mk(tbl[i].exp_re, tbl[i].exp_im), tbl[i].exp_last});
      end
    end
    check("single_err", {31'd0, frame_err}, 32'd0);

    // Streaming: four gapless frames with tready held high
    send_frame(16, 8, 7);
    ready_low = 0;
    mon_ready = 1'b1;
    send_frame(32, 8, 7);
    send_frame(48, 8, 7);
    send_frame(64, 8, 7);
    mon_ready = 1'b0;
    check("stream_tready_low", ready_low, 0);
    wait_beats(32);
    if (cap_cyc.size() >= 32) check("stream_contiguous", cap_cyc[31] - cap_cyc[0], 31);
    check_frame("stream_f0", 16);
    check_frame("stream_f1", 32);
    check_frame("stream_f2", 48);
    check_frame("stream_f3", 64);

    // Backpressure: 1,0,0,1 tready while three frames are driven
    bp_mode   = 1'b1;
    ready_low = 0;
    mon_ready = 1'b1;
    send_frame(80, 8, 7);
    send_frame(96, 8, 7);
    send_frame(112, 8, 7);
    mon_ready = 1'b0;
    wait_beats(24);
    bp_mode  = 1'b0;
    m_tready = 1'b1;
    check("bp_tready_low_seen", {31'd0, ready_low > 0}, 32'd1);
    check_frame("bp_f0", 80);
    check_frame("bp_f1", 96);
    check_frame("bp_f2", 112);
    idle(20);
    check("bp_no_extra", cap_q.size(), 0);
    check("bp_err", {31'd0, frame_err}, 32'd0);

    // Early tlast: 5-beat runt followed by a valid frame
    send_frame(200, 5, 4);
    send_frame(128, 8, 7);
    wait_beats(8);
    check_frame("early_frame", 128);
    check("early_err", {31'd0, frame_err}, 32'd1);
    idle(20);
    check("early_no_extra", cap_q.size(), 0);
    check("early_err_sticky", {31'd0, frame_err}, 32'd1);

    // Missing tlast: frame still emitted, error flagged
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("miss_err_cleared", {31'd0, frame_err}, 32'd0);
    send_frame(144, 8, -1);
    wait_beats(8);
    check_frame("miss_frame", 144);
    check("miss_err", {31'd0, frame_err}, 32'd1);

    // Async reset while output beat 3 is pending
    send_frame(160, 8, -1);
    for (int c = 0; c < 200 && cap_q.size() < 3; c++) begin
      @(posedge clk);
      #1;
    end
    m_tready = 1'b0;
    check("arst_three_taken", cap_q.size(), 3);
    check("arst_pending_valid", {31'd0, m_tvalid}, 32'd1);
    check("arst_pending_data", {8'd0, m_tdata}, {8'd0, mk(163, -163)});
    check("arst_pending_err", {31'd0, frame_err}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("arst_tlast", {31'd0, m_tlast}, 32'd0);
    check("arst_tdata", {8'd0, m_tdata}, 32'd0);
    check("arst_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cap_q.delete();
    cap_cyc.delete();
    idle(1);
    check("arst_tready", {31'd0, s_tready}, 32'd1);
    check("arst_idle_valid", {31'd0, m_tvalid}, 32'd0);
    m_tready = 1'b1;
    send_frame(176, 8, 7);
    wait_beats(8);
    check_frame("arst_frame", 176);
    idle(20);
    check("arst_no_extra", cap_q.size(), 0);
    check("arst_final_err", {31'd0, frame_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Downstream stage of the 8-point MDC FFT.
- Accepts FFT output frames over AXI-Stream in bit-reversed bin order and re-emits each frame in natural bin order (bin 0..N-1) over AXI-Stream with full backpressure.
- Uses a two-bank ping-pong buffer, so one frame can be written while the previous frame is read, sustaining 1 sample/cycle.
- Sits between fft_mdc's master port and the capture/analysis logic (ILA/VIO or a later magnitude stage).

Parameters:
- NB_DATA, 12, bits per real/imag component (matches FFT output width).
- N_POINT, 8, samples per frame; must be a power of two.
- LOG2_N, 3, log2(N_POINT); sizes the index counters.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- s_axis_data_tvalid  in  1  input sample valid.
- s_axis_data_tdata  in  2*NB_DATA  {re, im}, re in the MSBs, two's complement.
- s_axis_data_tlast  in  1  marks the last sample of an input frame.
- s_axis_data_tready  out  1  block can accept a sample.
- m_axis_data_tvalid  out  1  output sample valid.
- m_axis_data_tdata  out  2*NB_DATA  {re, im}, natural bin order.
- m_axis_data_tlast  out  1  asserted on bin N_POINT-1.
- m_axis_data_tready  in  1  downstream accepts the sample.
- o_frame_err  out  1  sticky flag: a tlast/length mismatch was seen since reset.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - m_axis_data_tvalid=0, m_axis_data_tdata=0, m_axis_data_tlast=0, o_frame_err=0.
  - Both bank-full flags cleared; wr_bank=0, rd_bank=0; all index counters=0.
  - s_axis_data_tready reads 1 from the first cycle after release.
- Reset mid-operation: all partial and complete frames are discarded. No output beat is produced for them.
- Storage: 2 banks x N_POINT words of 2*NB_DATA bits, held in flops. Read path is combinational into the output register.
- Write side:
  - s_axis_data_tready = !full[wr_bank].
  - On each handshake, write to address bitrev(wr_idx), then increment wr_idx.
  - Handshake with wr_idx==N_POINT-1 and tlast=1: set full[wr_bank], toggle wr_bank, wr_idx<=0.
  - Handshake with wr_idx==N_POINT-1 and tlast=0: commit the frame as above and set o_frame_err.
  - Handshake with tlast=1 and wr_idx<N_POINT-1 (early tlast): do not commit; wr_idx<=0; wr_bank unchanged; set o_frame_err. The partial frame is overwritten by the next frame.
- Read side:
  - The output register loads when (!m_axis_data_tvalid || m_axis_data_tready) and full[rd_bank].
  - Loaded value: tdata=bank[rd_bank][rd_idx], tvalid=1, tlast=(rd_idx==N_POINT-1). Then rd_idx increments.
  - When the word with rd_idx==N_POINT-1 is loaded: clear full[rd_bank], toggle rd_bank, rd_idx<=0.
  - When the register would load but full[rd_bank]=0 and the current beat is accepted: tvalid<=0.
  - tdata and tlast are held stable while tvalid=1 and tready=0 (AXIS compliance).
- Latency: the first output beat (bin 0) has tvalid high 2 clock edges after the edge accepting the last input beat. Edge 1 sets full; edge 2 loads the output register.
- Throughput:
  - With m_axis_data_tready held at 1, back-to-back frames stream gaplessly at 1 sample/cycle.
  - Both banks full causes s_axis_data_tready=0 until the read side releases a bank.
- Simultaneous events:
  - A commit and a release of different banks on the same edge are both honoured.
  - A bank released on edge k can be written from edge k+1 onward: the tready update is registered-flag based.
- Arithmetic: none. Data passes bit-exact. bitrev() reverses the LOG2_N bits of the index.

Decomposition:
- Shared package fft_pkg holds:
  - NB_FFT=12, N_POINT=8, LOG2_N=3.
  - the bitrev function.
  - the packing order of {re, im}.
- One natural sub-module: fft_pingpong_ram (2 banks, write port with bank/address, async read with bank/address).
- The top level holds the write/read control counters and the output register.

Test Plan:
- Single frame: input beats in arrival order carry re=0,4,2,6,1,5,3,7 with im=-re; the 8th beat has tlast. Required: output re=0..7 and im=0,-1..-7 in order; tlast only on re=7; first tvalid 2 edges after the last input handshake.
- Streaming, tready=1: 4 consecutive frames with no input gaps. Required: 32 contiguous output beats, each frame in natural order, s_axis_data_tready never deasserts after the first frame.
- Backpressure: m_axis_data_tready toggling 1,0,0,1 repeating while 3 frames are driven. Required:
  - tdata and tlast hold steady during stalls.
  - s_axis_data_tready=0 once both banks are full.
  - No sample is lost or duplicated.
- Early tlast: send 5 beats with tlast on the 5th, then a valid 8-beat frame. Required: o_frame_err=1 and stays 1; only the valid frame is output (8 beats, correct order).
- Missing tlast: 8 beats without tlast. Required: frame is output in natural order, and o_frame_err=1.
- Async reset mid-frame: assert i_rst_n=0 for 1 cycle between clock edges while output beat 3 is pending. Required:
  - tvalid, tlast, tdata and o_frame_err clear immediately.
  - After release, tready=1 and the next full frame is output correctly.
